ibus_arb: RTL

//  Sequences and shares the single-port instruction memory (sync read, 1-cycle latency)

---
 rtl/ibus_arb_pkg.sv | 14 +
 rtl/ibus_arb_starve.sv | 38 +++
 rtl/ibus_arb.sv | 104 ++++++++++
 3 files changed

// File: rtl/ibus_arb_pkg.sv
// Shared definitions for the instruction-bus arbiter: FSM state encoding and
// the reset-state selection helper.
package ibus_arb_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic state_e reset_state(input int boot_on_rst);
        return (boot_on_rst != 0) ? ST_BOOT : ST_RUN;
    endfunction

endpackage

// File: rtl/ibus_arb_starve.sv
// Saturating count of consecutive denied loader-request cycles in RUN; raises
// win_o once the loader has waited STARVE cycles so it takes the next slot.
module ibus_arb_starve #(
    parameter int STARVE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic l_req_i,
    input  logic l_gnt_i,
    output logic win_o
);

    localparam int CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || !l_req_i || l_gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign win_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/ibus_arb.sv
// Shares a single-port sync-read instruction memory between the core fetch port
// and a loader/debug port, with a BOOT mode that holds the core off the bus.
module ibus_arb
    import ibus_arb_pkg::*;
#(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int STARVE      = 4,
    parameter int BOOT_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          boot_req,
    input  logic          boot_done,
    output logic          cpu_hold,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_din,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_din,
    output logic          m_we,
    input  logic [DW-1:0] m_dout
);

    localparam state_e RST_STATE = reset_state(BOOT_ON_RST);

    state_e state_q, state_d;
    logic   f_rd_q, l_rd_q;
    logic   run;
    logic   l_win;

    assign run = (state_q == ST_RUN);

    ibus_arb_starve #(
        .STARVE (STARVE)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .run_i   (run),
        .l_req_i (l_req),
        .l_gnt_i (l_gnt),
        .win_o   (l_win)
    );

    // Simultaneous boot_req and boot_done leave the state untouched.
    always_comb begin
        state_d = state_q;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        case (state_q)
            ST_BOOT: begin
                l_gnt = l_req;
                if (boot_done && !boot_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (l_req && l_win) begin
                    l_gnt = 1'b1;
                end else begin
                    f_gnt = f_req;
                    l_gnt = l_req & ~f_req;
                end
                if (boot_req && !boot_done) begin
                    state_d = ST_BOOT;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            f_rd_q  <= 1'b0;
            l_rd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            f_rd_q  <= f_gnt;
            l_rd_q  <= l_gnt & ~l_we;
        end
    end

    assign cpu_hold = (state_q == ST_BOOT);

    assign m_addr = f_gnt ? f_addr : l_addr;
    assign m_din  = l_din;
    assign m_we   = l_gnt & l_we;

    assign f_rvalid = f_rd_q;
    assign l_rvalid = l_rd_q;
    assign f_rdata  = m_dout;
    assign l_rdata  = m_dout;

endmodule
